// File: rtl/px_pkg.sv
// Shared display package: scan FSM state encoding and width helpers.
package px_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DWELL = 2'd1,
    ST_BLANK = 2'd2
  } px_state_e;

  // Ceiling log2, never narrower than one bit so every derived bus is legal.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int max2(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/px_scan_controller_if.sv
// Scan-controller bus: scan-rate tick and digit mask in, anode/select/status out.
interface px_scan_controller_if #(
  parameter int NUM_DIGITS = 8
);
  localparam int SEL_W = px_pkg::clog2(NUM_DIGITS);

  logic                  tick;
  logic [NUM_DIGITS-1:0] en_mask;
  logic [NUM_DIGITS-1:0] a;
  logic [SEL_W-1:0]      seg_sel;
  logic                  blank;
  logic                  frame_sync;

  modport master (
    output tick, en_mask,
    input  a, seg_sel, blank, frame_sync
  );

  modport slave (
    input  tick, en_mask,
    output a, seg_sel, blank, frame_sync
  );

endinterface

// File: rtl/px_next_digit.sv
// Circular search for the first enabled digit strictly after idx; returns idx
// itself when no other digit is enabled.
module px_next_digit
  import px_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int SEL_W      = clog2(NUM_DIGITS)
) (
  input  logic [NUM_DIGITS-1:0] mask,
  input  logic [SEL_W-1:0]      idx,
  output logic [SEL_W-1:0]      next_idx
);

  localparam logic [SEL_W:0] N_W = (SEL_W + 1)'(NUM_DIGITS);

  logic [SEL_W-1:0]      cand [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] hit;

  // cand[gi] is the digit gi+1 positions above idx, wrapped into range.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_cand
      localparam logic [SEL_W:0] OFF = (SEL_W + 1)'(gi + 1);
      logic [SEL_W:0] sum;
      assign sum      = {1'b0, idx} + OFF;
      assign cand[gi] = (sum >= N_W) ? SEL_W'(sum - N_W) : SEL_W'(sum);
      assign hit[gi]  = mask[cand[gi]];
    end
  endgenerate

  always_comb begin
    next_idx = idx;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (hit[i]) next_idx = cand[i];
    end
  end

endmodule

// File: rtl/px_scan_controller.sv
// Multiplexed display scan controller: walks enabled digits with a dwell period
// and optional dark gap, driving active-low anodes and the segment-data select.
module px_scan_controller
  import px_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int DWELL_TICKS = 1,
  parameter int BLANK_TICKS = 1
) (
  input  logic                clk,
  input  logic                reset,
  px_scan_controller_if.slave bus
);

  localparam int SEL_W = clog2(NUM_DIGITS);
  localparam int CNT_W = clog2(max2(DWELL_TICKS, BLANK_TICKS) + 1);

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_TICKS - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);
  localparam logic [SEL_W-1:0] LAST_IDX   = SEL_W'(NUM_DIGITS - 1);

  px_state_e        state_reg, state_next;
  logic [SEL_W-1:0] idx_reg, idx_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             frame_sync_reg, frame_sync_next;

  logic [NUM_DIGITS-1:0] en_mask;
  logic                  any_en;
  logic [SEL_W-1:0]      step_idx;
  logic [SEL_W-1:0]      first_idx;
  logic [NUM_DIGITS-1:0] a_drv;
  logic                  blank_drv;
  logic                  lit;

  assign en_mask = bus.en_mask;
  assign any_en  = |en_mask;

  px_next_digit #(.NUM_DIGITS(NUM_DIGITS), .SEL_W(SEL_W)) u_step (
    .mask     (en_mask),
    .idx      (idx_reg),
    .next_idx (step_idx)
  );

  // Searching upward from the top digit yields the lowest enabled digit.
  px_next_digit #(.NUM_DIGITS(NUM_DIGITS), .SEL_W(SEL_W)) u_first (
    .mask     (en_mask),
    .idx      (LAST_IDX),
    .next_idx (first_idx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      idx_reg        <= '0;
      cnt_reg        <= '0;
      frame_sync_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      cnt_reg        <= cnt_next;
      frame_sync_reg <= frame_sync_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    idx_next        = idx_reg;
    cnt_next        = cnt_reg;
    frame_sync_next = 1'b0;
    if (bus.tick) begin
      unique case (state_reg)
        ST_IDLE: begin
          if (any_en) begin
            state_next      = ST_DWELL;
            idx_next        = first_idx;
            cnt_next        = '0;
            frame_sync_next = 1'b1;
          end
        end
        ST_DWELL: begin
          if (!any_en) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
          end else if (cnt_reg == DWELL_LAST) begin
            // Index moves now so seg_sel settles during any following blank.
            state_next      = (BLANK_TICKS > 0) ? ST_BLANK : ST_DWELL;
            idx_next        = step_idx;
            cnt_next        = '0;
            frame_sync_next = (step_idx <= idx_reg);
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        ST_BLANK: begin
          if (!any_en) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
          end else if (cnt_reg == BLANK_LAST) begin
            state_next = ST_DWELL;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        default: begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Anode gating uses the live mask so a digit disabled mid-dwell goes dark at once.
  always_comb begin
    lit       = (state_reg == ST_DWELL) && en_mask[idx_reg];
    a_drv     = '1;
    blank_drv = 1'b1;
    if (lit) begin
      a_drv[idx_reg] = 1'b0;
      blank_drv      = 1'b0;
    end
  end

  assign bus.a          = a_drv;
  assign bus.blank      = blank_drv;
  assign bus.seg_sel    = idx_reg;
  assign bus.frame_sync = frame_sync_reg;

endmodule

// File: tb/tb_px_scan_controller.sv
// Directed bench for px_scan_controller: blanked and blank-free instances.
module tb_px_scan_controller;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  px_scan_controller_if #(.NUM_DIGITS(8)) bus_a ();
  px_scan_controller_if #(.NUM_DIGITS(8)) bus_b ();

  px_scan_controller #(.NUM_DIGITS(8), .DWELL_TICKS(1), .BLANK_TICKS(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  px_scan_controller #(.NUM_DIGITS(8), .DWELL_TICKS(2), .BLANK_TICKS(0)) dut_nb (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  task automatic pulse_tick(input bit which);
    @(negedge clk);
    if (which) bus_b.tick = 1'b1;
    else       bus_a.tick = 1'b1;
    @(negedge clk);
    bus_a.tick = 1'b0;
    bus_b.tick = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset         = 1'b1;
    bus_a.en_mask = 8'hFF;
    bus_a.tick    = 1'b1;
    bus_b.en_mask = 8'hFF;
    bus_b.tick    = 1'b1;
    repeat (2) @(negedge clk);
    bus_a.tick = 1'b0;
    bus_b.tick = 1'b0;
    checks++;
    if (bus_a.a !== 8'hFF || bus_a.blank !== 1'b1 || bus_a.seg_sel !== 3'd0 || bus_a.frame_sync !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: a=%h blank=%b sel=%0d fs=%b, need a=FF blank=1 sel=0 fs=0",
               bus_a.a, bus_a.blank, bus_a.seg_sel, bus_a.frame_sync);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus_a.a !== 8'hFF || bus_a.blank !== 1'b1 || bus_a.seg_sel !== 3'd0 || bus_a.frame_sync !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: a=%h blank=%b sel=%0d fs=%b, need a=FF blank=1 sel=0 fs=0",
               bus_a.a, bus_a.blank, bus_a.seg_sel, bus_a.frame_sync);
    end
    checks++;
    if (bus_b.a !== 8'hFF || bus_b.blank !== 1'b1 || bus_b.frame_sync !== 1'b0) begin
      errors++;
      $display("FAIL reset_nb: a=%h blank=%b fs=%b, need a=FF blank=1 fs=0",
               bus_b.a, bus_b.blank, bus_b.frame_sync);
    end
  endtask

  task automatic test_full_scan();
    logic [7:0] exp_a [0:16];
    logic [7:0] held;
    exp_a = '{8'hFE, 8'hFF, 8'hFD, 8'hFF, 8'hFB, 8'hFF, 8'hF7, 8'hFF, 8'hEF,
              8'hFF, 8'hDF, 8'hFF, 8'hBF, 8'hFF, 8'h7F, 8'hFF, 8'hFE};
    do_reset();
    bus_a.en_mask = 8'hFF;
    for (int k = 0; k < 17; k++) begin
      pulse_tick(1'b0);
      checks++;
      if (bus_a.a !== exp_a[k] || bus_a.blank !== 1'((k % 2) == 1)) begin
        errors++;
        $display("FAIL full_scan_a[%0d]: a=%h blank=%b, need a=%h blank=%b",
                 k, bus_a.a, bus_a.blank, exp_a[k], (k % 2) == 1);
      end
      checks++;
      if (bus_a.seg_sel !== 3'(((k + 1) / 2) % 8)) begin
        errors++;
        $display("FAIL full_scan_sel[%0d]: sel=%0d, need %0d", k, bus_a.seg_sel, ((k + 1) / 2) % 8);
      end
      checks++;
      if (bus_a.frame_sync !== 1'(k == 0 || k == 15)) begin
        errors++;
        $display("FAIL full_scan_fs[%0d]: fs=%b, need %b", k, bus_a.frame_sync, (k == 0 || k == 15));
      end
      held = bus_a.a;
      repeat (3) @(negedge clk);
      checks++;
      if (bus_a.frame_sync !== 1'b0 || bus_a.a !== held) begin
        errors++;
        $display("FAIL full_scan_hold[%0d]: fs=%b a=%h, need fs=0 a=%h", k, bus_a.frame_sync, bus_a.a, held);
      end
    end
  endtask

  task automatic test_single_digit();
    logic [7:0] exp_a  [0:5];
    logic       exp_fs [0:5];
    exp_a  = '{8'hEF, 8'hFF, 8'hEF, 8'hFF, 8'hEF, 8'hFF};
    exp_fs = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    bus_a.en_mask = 8'h10;
    for (int k = 0; k < 6; k++) begin
      pulse_tick(1'b0);
      checks++;
      if (bus_a.a !== exp_a[k] || bus_a.frame_sync !== exp_fs[k] || bus_a.seg_sel !== 3'd4) begin
        errors++;
        $display("FAIL single_digit[%0d]: a=%h fs=%b sel=%0d, need a=%h fs=%b sel=4",
                 k, bus_a.a, bus_a.frame_sync, bus_a.seg_sel, exp_a[k], exp_fs[k]);
      end
    end
  endtask

  task automatic test_mid_dwell_disable();
    do_reset();
    bus_a.en_mask = 8'hFF;
    pulse_tick(1'b0);
    checks++;
    if (bus_a.a !== 8'hFE) begin
      errors++;
      $display("FAIL disable_lit: a=%h, need FE", bus_a.a);
    end
    @(negedge clk);
    bus_a.en_mask = 8'hFE;
    #1;
    checks++;
    if (bus_a.a !== 8'hFF || bus_a.blank !== 1'b1) begin
      errors++;
      $display("FAIL disable_gate: a=%h blank=%b, need a=FF blank=1", bus_a.a, bus_a.blank);
    end
    pulse_tick(1'b0);
    checks++;
    if (bus_a.a !== 8'hFF || bus_a.seg_sel !== 3'd1 || bus_a.frame_sync !== 1'b0) begin
      errors++;
      $display("FAIL disable_blank: a=%h sel=%0d fs=%b, need a=FF sel=1 fs=0",
               bus_a.a, bus_a.seg_sel, bus_a.frame_sync);
    end
    pulse_tick(1'b0);
    checks++;
    if (bus_a.a !== 8'hFD || bus_a.blank !== 1'b0) begin
      errors++;
      $display("FAIL disable_next: a=%h blank=%b, need a=FD blank=0", bus_a.a, bus_a.blank);
    end
  endtask

  task automatic test_mask_zero();
    do_reset();
    bus_a.en_mask = 8'hFF;
    repeat (3) pulse_tick(1'b0);
    checks++;
    if (bus_a.a !== 8'hFD) begin
      errors++;
      $display("FAIL mask_zero_pre: a=%h, need FD", bus_a.a);
    end
    bus_a.en_mask = 8'h00;
    pulse_tick(1'b0);
    checks++;
    if (bus_a.a !== 8'hFF || bus_a.blank !== 1'b1 || bus_a.frame_sync !== 1'b0 || bus_a.seg_sel !== 3'd1) begin
      errors++;
      $display("FAIL mask_zero_idle: a=%h blank=%b fs=%b sel=%0d, need a=FF blank=1 fs=0 sel=1",
               bus_a.a, bus_a.blank, bus_a.frame_sync, bus_a.seg_sel);
    end
    bus_a.en_mask = 8'h0C;
    pulse_tick(1'b0);
    checks++;
    if (bus_a.a !== 8'hFB || bus_a.frame_sync !== 1'b1 || bus_a.seg_sel !== 3'd2) begin
      errors++;
      $display("FAIL mask_restore: a=%h fs=%b sel=%0d, need a=FB fs=1 sel=2",
               bus_a.a, bus_a.frame_sync, bus_a.seg_sel);
    end
  endtask

  task automatic test_reset_in_blank();
    bus_a.en_mask = 8'hFF;
    pulse_tick(1'b0);
    checks++;
    if (bus_a.a !== 8'hFF || bus_a.seg_sel !== 3'd3) begin
      errors++;
      $display("FAIL rst_blank_pre: a=%h sel=%0d, need a=FF sel=3", bus_a.a, bus_a.seg_sel);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (bus_a.a !== 8'hFF || bus_a.seg_sel !== 3'd0 || bus_a.blank !== 1'b1) begin
      errors++;
      $display("FAIL rst_blank_async: a=%h sel=%0d blank=%b, need a=FF sel=0 blank=1",
               bus_a.a, bus_a.seg_sel, bus_a.blank);
    end
    @(negedge clk);
    reset         = 1'b0;
    bus_a.en_mask = 8'h28;
    pulse_tick(1'b0);
    checks++;
    if (bus_a.a !== 8'hF7 || bus_a.frame_sync !== 1'b1 || bus_a.seg_sel !== 3'd3) begin
      errors++;
      $display("FAIL rst_blank_first: a=%h fs=%b sel=%0d, need a=F7 fs=1 sel=3",
               bus_a.a, bus_a.frame_sync, bus_a.seg_sel);
    end
  endtask

  task automatic test_no_blank();
    logic [7:0] exp_a  [0:6];
    logic       exp_fs [0:6];
    exp_a  = '{8'hFE, 8'hFE, 8'hFB, 8'hFB, 8'hDF, 8'hDF, 8'hFE};
    exp_fs = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    bus_b.en_mask = 8'b0010_0101;
    for (int k = 0; k < 7; k++) begin
      pulse_tick(1'b1);
      checks++;
      if (bus_b.a !== exp_a[k] || bus_b.frame_sync !== exp_fs[k] || bus_b.blank !== 1'b0) begin
        errors++;
        $display("FAIL no_blank[%0d]: a=%h fs=%b blank=%b, need a=%h fs=%b blank=0",
                 k, bus_b.a, bus_b.frame_sync, bus_b.blank, exp_a[k], exp_fs[k]);
      end
    end
  endtask

  initial begin
    reset         = 1'b1;
    bus_a.tick    = 1'b0;
    bus_a.en_mask = 8'h00;
    bus_b.tick    = 1'b0;
    bus_b.en_mask = 8'h00;
    test_reset();
    test_full_scan();
    test_single_digit();
    test_mid_dwell_disable();
    test_mask_zero();
    test_reset_in_blank();
    test_no_blank();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
